mul_unit_ctrl: RTL and testbench

// - Issue/writeback controller for the pipelined RV32M multiplier (multiplier_pipeline).
// - Accepts one MUL/MULH/MULHSU/MULHU per cycle from the multiply reservation station.
// - Carries ROB index, dest preg and op alongside the datapath in a matched valid/tag pipe.
// - Selects the result half, presents it to the CDB arbiter, and freezes the pipe on CDB

---
 rtl/mul_pkg.sv | 38 +++
 rtl/mul_tag_pipe.sv | 48 ++++
 rtl/mul_unit_ctrl.sv | 78 +++++++
 tb/tb_mul_unit_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the RV32M multiply issue/writeback controller.
// The ROB-index and preg widths below size the tag-pipe bundle.
package mul_pkg;

  localparam int MUL_ROB_IDX_W = 5;
  localparam int MUL_PREG_W    = 6;

  // Signedness code understood by multiplier_pipeline: bit0 = A signed, bit1 = B signed.
  typedef enum logic [1:0] {
    MUL_UU = 2'b00,
    MUL_SU = 2'b01,
    MUL_SS = 2'b11
  } mul_type_e;

  // funct3[1:0] of the M-extension multiply group.
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef struct packed {
    logic                     valid;
    mul_op_e                  op;
    logic [MUL_ROB_IDX_W-1:0] rob_idx;
    logic [MUL_PREG_W-1:0]    pd;
  } mul_tag_t;

  function automatic mul_type_e op_to_mul_type(mul_op_e op);
    case (op)
      OP_MULHSU: return MUL_SU;
      OP_MULHU:  return MUL_UU;
      default:   return MUL_SS;
    endcase
  endfunction

endpackage

// File: rtl/mul_tag_pipe.sv
// Registered tag pipe running in lockstep with multiplier_pipeline.
// hold freezes every stage; clear drops every valid bit and wins over hold.
module mul_tag_pipe
  import mul_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     hold,
  input  logic     clear,
  input  mul_tag_t in_tag,
  output mul_tag_t tail_tag,
  output logic     any_valid
);

  mul_tag_t stage_q [STAGES];
  mul_tag_t stage_d [STAGES];

  always_comb begin
    // NOTE: start from the current state so every path assigns stage_d; no latch is inferred.
    stage_d = stage_q;
    if (clear) begin
      for (int i = 0; i < STAGES; i++) stage_d[i].valid = 1'b0;
    end else if (!hold) begin
      stage_d[0] = in_tag;
      for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < STAGES; i++) any_valid = any_valid | stage_q[i].valid;
  end

  assign tail_tag = stage_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a handful of flops, not a RAM, so it is reset in full (tags to 0 too).
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so each stage reads its neighbour's pre-edge value.
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/mul_unit_ctrl.sv
// Issue/writeback controller for the pipelined RV32M multiplier: drives operands,
// tracks ops in a matched tag pipe, selects the result half and handles stall/flush.
module mul_unit_ctrl
  import mul_pkg::*;
#(
  parameter int DEPTH     = 1,
  parameter int ROB_IDX_W = MUL_ROB_IDX_W,
  parameter int PREG_W    = MUL_PREG_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [1:0]           issue_op,
  input  logic [31:0]          issue_rs1,
  input  logic [31:0]          issue_rs2,
  input  logic [ROB_IDX_W-1:0] issue_rob_idx,
  input  logic [PREG_W-1:0]    issue_pd,
  input  logic                 flush,
  output logic                 mul_stall,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output mul_type_e            mul_type,
  input  logic [63:0]          mul_p,
  output logic                 cdb_valid,
  input  logic                 cdb_ready,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [PREG_W-1:0]    cdb_pd,
  output logic [31:0]          cdb_data,
  output logic                 busy
);

  localparam int STAGES = DEPTH + 1;

  mul_tag_t issue_tag;
  mul_tag_t tail_tag;
  logic     tag_any_valid;

  // A stalled tail freezes the multiplier and the tag pipe together; flush overrides the stall
  // so the kill always lands on the next edge.
  always_comb begin
    mul_stall   = tail_tag.valid & ~cdb_ready & ~flush;
    issue_ready = ~mul_stall & ~flush;
    issue_tag   = '{valid:   issue_valid & issue_ready,
                    op:      mul_op_e'(issue_op),
                    rob_idx: issue_rob_idx,
                    pd:      issue_pd};
  end

  assign mul_a    = issue_rs1;
  assign mul_b    = issue_rs2;
  assign mul_type = op_to_mul_type(mul_op_e'(issue_op));

  mul_tag_pipe #(
    .STAGES (STAGES)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (mul_stall),
    .clear     (flush),
    .in_tag    (issue_tag),
    .tail_tag  (tail_tag),
    .any_valid (tag_any_valid)
  );

  // MUL returns the low word; every high-half variant returns the upper word.
  always_comb begin
    cdb_valid   = tail_tag.valid;
    cdb_rob_idx = tail_tag.rob_idx;
    cdb_pd      = tail_tag.pd;
    cdb_data    = (tail_tag.op == OP_MUL) ? mul_p[31:0] : mul_p[63:32];
    busy        = tag_any_valid;
  end

  cdb_data_known_a : assert property (@(posedge clk) disable iff (!rst_n)
    cdb_valid |-> !$isunknown(cdb_data));

endmodule

// File: tb/tb_mul_unit_ctrl.sv
// Bench for mul_unit_ctrl with a behavioural multiplier_pipeline and a queue scoreboard.
module tb_mul_unit_ctrl;
  import mul_pkg::*;

  localparam int DEPTH     = 1;
  localparam int ROB_IDX_W = 5;
  localparam int PREG_W    = 6;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [1:0]           issue_op;
  logic [31:0]          issue_rs1;
  logic [31:0]          issue_rs2;
  logic [ROB_IDX_W-1:0] issue_rob_idx;
  logic [PREG_W-1:0]    issue_pd;
  logic                 flush;
  logic                 mul_stall;
  logic [31:0]          mul_a;
  logic [31:0]          mul_b;
  logic [1:0]           mul_type;
  logic [63:0]          mul_p;
  logic                 cdb_valid;
  logic                 cdb_ready;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [PREG_W-1:0]    cdb_pd;
  logic [31:0]          cdb_data;
  logic                 busy;

  mul_unit_ctrl #(
    .DEPTH     (DEPTH),
    .ROB_IDX_W (ROB_IDX_W),
    .PREG_W    (PREG_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rob_idx (issue_rob_idx),
    .issue_pd      (issue_pd),
    .flush         (flush),
    .mul_stall     (mul_stall),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_type      (mul_type),
    .mul_p         (mul_p),
    .cdb_valid     (cdb_valid),
    .cdb_ready     (cdb_ready),
    .cdb_rob_idx   (cdb_rob_idx),
    .cdb_pd        (cdb_pd),
    .cdb_data      (cdb_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier_pipeline: DEPTH+1 product registers, frozen by mul_stall.
  function automatic logic [63:0] env_prod(input logic [1:0] t, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{t[0] & a[31]}}, a};
    eb = {{32{t[1] & b[31]}}, b};
    return ea * eb;
  endfunction

  logic [63:0] mpipe [DEPTH+1];
  always @(posedge clk) begin
    if (!mul_stall) begin
      mpipe[0] <= env_prod(mul_type, mul_a, mul_b);
      for (int i = 1; i <= DEPTH; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_p = mpipe[DEPTH];

  // Independent reference for random stimulus, written from the ISA definition.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] tmp;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      2'b00:   begin tmp = ua * ub; return tmp[31:0];  end
      2'b01:   begin tmp = sa * sb; return tmp[63:32]; end
      2'b10:   begin tmp = sa * ub; return tmp[63:32]; end
      default: begin tmp = ua * ub; return tmp[63:32]; end
    endcase
  endfunction

  typedef struct {
    logic [ROB_IDX_W-1:0] rob;
    logic [PREG_W-1:0]    pd;
    logic [31:0]          data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every CDB handshake pops one expected result in order.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && flush) begin
      exp_q.delete();
    end else if (rst_n && cdb_valid && cdb_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: rob=%0d data=0x%0h, expected no result", cdb_rob_idx,
                 cdb_data);
      end else begin
        e = exp_q.pop_front();
        check("cdb_rob_idx", 64'(cdb_rob_idx), 64'(e.rob));
        check("cdb_pd", 64'(cdb_pd), 64'(e.pd));
        check("cdb_data", 64'(cdb_data), 64'(e.data));
      end
    end
  end

  // Drives one op from posedge+1 until accepted; the expectation is queued at acceptance.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [ROB_IDX_W-1:0] rob, input logic [PREG_W-1:0] pd,
                       input logic [31:0] exp, input bit rnd_ready);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    issue_valid = 1'b1;
    issue_op = op;
    issue_rs1 = a;
    issue_rs2 = b;
    issue_rob_idx = rob;
    issue_pd = pd;
    while (!done) begin
      @(negedge clk);
      if (issue_ready) begin
        exp_q.push_back('{rob: rob, pd: pd, data: exp});
        last_accept_cyc = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rnd_ready) cdb_ready = 1'($urandom_range(0, 1));
      n++;
      if (!done && n > 100) begin
        checks++;
        failures++;
        $display("FAIL issue_timeout: rob=%0d not accepted, expected acceptance", rob);
        done = 1'b1;
      end
    end
    issue_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    cdb_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [1:0] type_tbl [4];
    int first_cyc;
    int n;
    type_tbl = '{2'b11, 2'b11, 2'b01, 2'b00};

    rst_n = 1'b0;
    issue_valid = 1'b0;
    issue_op = 2'b00;
    issue_rs1 = '0;
    issue_rs2 = '0;
    issue_rob_idx = '0;
    issue_pd = '0;
    flush = 1'b0;
    cdb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_issue_ready", 64'(issue_ready), 64'd1);
    check("reset_mul_stall", 64'(mul_stall), 64'd0);

    // Operand pass-through and signedness mapping (issue_valid low, nothing accepted).
    @(posedge clk);
    #1;
    issue_rs1 = 32'h1234_5678;
    issue_rs2 = 32'h9abc_def0;
    for (int i = 0; i < 4; i++) begin
      issue_op = 2'(i);
      #0.5;
      check("mul_type", 64'(mul_type), 64'(type_tbl[i]));
    end
    check("mul_a", 64'(mul_a), 64'h1234_5678);
    check("mul_b", 64'(mul_b), 64'h9abc_def0);
    @(posedge clk);
    #1;

    // Single MUL: latency DEPTH+1 cycles, data 42.
    issue(2'b00, 32'd7, 32'd6, 5'd3, 6'd9, 32'd42, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cdb_valid && n < 20);
    check("latency", 64'(cyc - last_accept_cyc), 64'(DEPTH + 1));
    drain();

    // High-half variants.
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4, 6'd10, 32'h4000_0000, 1'b0);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 6'd11, 32'hFFFF_FFFE, 1'b0);
    issue(2'b10, 32'hFFFF_FFFF, 32'd2, 5'd6, 6'd12, 32'hFFFF_FFFF, 1'b0);
    drain();

    // Backpressure: four back-to-back issues, tail held for three cycles.
    cdb_ready = 1'b0;
    fork
      begin
        issue(2'b00, 32'd3, 32'd5, 5'd10, 6'd20, 32'd15, 1'b0);
        issue(2'b00, 32'd100, 32'd100, 5'd11, 6'd21, 32'd10000, 1'b0);
        issue(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd12, 6'd22, 32'd1, 1'b0);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 6'd23, 32'd0, 1'b0);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!mul_stall && n < 20);
        for (int k = 0; k < 3; k++) begin
          check("bp_mul_stall", 64'(mul_stall), 64'd1);
          check("bp_issue_ready", 64'(issue_ready), 64'd0);
          check("bp_cdb_valid", 64'(cdb_valid), 64'd1);
          check("bp_cdb_rob_idx", 64'(cdb_rob_idx), 64'd10);
          check("bp_cdb_data", 64'(cdb_data), 64'd15);
          if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 cdb_ready = 1'b1;
      end
    join
    drain();

    // Flush with two ops in flight and the tail stalled; cdb_ready=1 in the flush cycle.
    cdb_ready = 1'b0;
    issue(2'b00, 32'd2, 32'd2, 5'd20, 6'd30, 32'd4, 1'b0);
    issue(2'b00, 32'd3, 32'd3, 5'd21, 6'd31, 32'd9, 1'b0);
    @(negedge clk);
    check("pre_flush_stall", 64'(mul_stall), 64'd1);
    check("pre_flush_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    cdb_ready = 1'b1;
    #1;
    check("flush_issue_ready", 64'(issue_ready), 64'd0);
    check("flush_mul_stall", 64'(mul_stall), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("post_flush_cdb_valid", 64'(cdb_valid), 64'd0);
    check("post_flush_busy", 64'(busy), 64'd0);
    issue(2'b11, 32'h0000_0003, 32'h8000_0000, 5'd22, 6'd1, 32'd1, 1'b0);
    drain();

    // Full pipe with continuous cdb_ready: one acceptance per cycle.
    cdb_ready = 1'b1;
    issue(2'b00, 32'd1, 32'd1, 5'd0, 6'd0, 32'd1, 1'b0);
    first_cyc = last_accept_cyc;
    for (int i = 1; i < 6; i++)
      issue(2'b00, 32'(i + 1), 32'd10, 5'(i), 6'(i), 32'((i + 1) * 10), 1'b0);
    check("full_pipe_throughput", 64'(last_accept_cyc - first_cyc), 64'd5);
    drain();

    // Asynchronous reset mid-stream, asserted and released off the clock edge.
    cdb_ready = 1'b0;
    issue(2'b00, 32'd9, 32'd9, 5'd1, 6'd2, 32'd81, 1'b0);
    issue(2'b00, 32'd8, 32'd8, 5'd2, 6'd3, 32'd64, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    #13 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cdb_ready = 1'b1;
    check("post_rst_issue_ready", 64'(issue_ready), 64'd1);
    check("post_rst_cdb_valid", 64'(cdb_valid), 64'd0);
    issue(2'b10, 32'hFFFF_FFFF, 32'd2, 5'd7, 6'd1, 32'hFFFF_FFFF, 1'b0);
    drain();

    // Random ops and operands under random backpressure vs the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      issue(op, a, b, 5'(i), 6'(i + 17), ref_result(op, a, b), 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
